// File: rtl/csel_sub_16b_pipe_pkg.sv
// Shared constants and the stage-1 payload record for the pipelined
// carry-select subtractor.
package csel_sub_16b_pipe_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SLICE = 4;
  localparam int unsigned HALF  = WIDTH / 2;

  // Everything stage 2 needs to finish the upper half of the difference.
  typedef struct packed {
    logic [HALF-1:0] diff_lo;
    logic            c8;
    logic [HALF-1:0] a_hi;
    logic [HALF-1:0] b_hi;
  } s1_payload_t;

endpackage : csel_sub_16b_pipe_pkg

// File: rtl/csel_sub_16b_pipe_slice.sv
// One 4-bit slice of the subtractor: sum = a + ~b + cin, with carry-out.
module sub_slice_4b
  import csel_sub_16b_pipe_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0] total;

  // Widen by one bit so the carry-out falls out of the add.
  always_comb begin
    total = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, cin};
    sum   = total[SLICE-1:0];
    cout  = total[SLICE];
  end

endmodule : sub_slice_4b

// File: rtl/csel_sub_16b_pipe.sv
// Two-stage pipelined 16-bit subtractor (A - B - Bin) built from 4-bit
// carry-select slices, with a valid/ready handshake on both sides.
module csel_sub_16b_pipe
  import csel_sub_16b_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_adv;
  logic        s1_load;
  logic        s2_load;
  s1_payload_t s1_d;
  s1_payload_t s1_q;

  // Stage-1 slice results
  logic [SLICE-1:0] s1_sum0;
  logic [SLICE-1:0] s1_sum1_c0;
  logic [SLICE-1:0] s1_sum1_c1;
  logic             c4;
  logic             c8_c0;
  logic             c8_c1;

  // Stage-2 slice results
  logic [SLICE-1:0] s2_sum2_c0;
  logic [SLICE-1:0] s2_sum2_c1;
  logic [SLICE-1:0] s2_sum3_c0;
  logic [SLICE-1:0] s2_sum3_c1;
  logic             c12_c0;
  logic             c12_c1;
  logic             c16_c0;
  logic             c16_c1;
  logic             c12;
  logic             c16;
  logic [WIDTH-1:0] diff_full;
  logic             bout_d;
  logic             ovf_d;

  // Handshake: stage 1 may move on when stage 2 is empty or draining;
  // in_ready therefore depends only on pipeline state and out_ready.
  always_comb begin
    s1_adv   = !s2_valid || out_ready;
    in_ready = !s1_valid || s1_adv;
    s1_load  = in_valid && in_ready;
    s2_load  = s1_valid && s1_adv;
  end

  // ---------------- Stage 1: bits 7:0 ----------------
  // Bits 3:0 ripple from the inverted borrow-in.
  sub_slice_4b u_s1_slice0 (
    .a    (A[3:0]),
    .b    (B[3:0]),
    .cin  (~Bin),
    .sum  (s1_sum0),
    .cout (c4)
  );

  // Bits 7:4 computed for both carry assumptions.
  sub_slice_4b u_s1_slice1_c0 (
    .a    (A[7:4]),
    .b    (B[7:4]),
    .cin  (1'b0),
    .sum  (s1_sum1_c0),
    .cout (c8_c0)
  );

  sub_slice_4b u_s1_slice1_c1 (
    .a    (A[7:4]),
    .b    (B[7:4]),
    .cin  (1'b1),
    .sum  (s1_sum1_c1),
    .cout (c8_c1)
  );

  // Select the upper slice of the low half by c4 and assemble the payload.
  always_comb begin
    s1_d         = '0;
    s1_d.diff_lo = {(c4 ? s1_sum1_c1 : s1_sum1_c0), s1_sum0};
    s1_d.c8      = c4 ? c8_c1 : c8_c0;
    s1_d.a_hi    = A[WIDTH-1:HALF];
    s1_d.b_hi    = B[WIDTH-1:HALF];
  end

  // Stage-1 valid flag; it loads whenever the slot is free or moving on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // Stage-1 payload changes only on an accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else if (s1_load) begin
      s1_q <= s1_d;
    end
  end

  // ---------------- Stage 2: bits 15:8 ----------------
  sub_slice_4b u_s2_slice2_c0 (
    .a    (s1_q.a_hi[3:0]),
    .b    (s1_q.b_hi[3:0]),
    .cin  (1'b0),
    .sum  (s2_sum2_c0),
    .cout (c12_c0)
  );

  sub_slice_4b u_s2_slice2_c1 (
    .a    (s1_q.a_hi[3:0]),
    .b    (s1_q.b_hi[3:0]),
    .cin  (1'b1),
    .sum  (s2_sum2_c1),
    .cout (c12_c1)
  );

  sub_slice_4b u_s2_slice3_c0 (
    .a    (s1_q.a_hi[7:4]),
    .b    (s1_q.b_hi[7:4]),
    .cin  (1'b0),
    .sum  (s2_sum3_c0),
    .cout (c16_c0)
  );

  sub_slice_4b u_s2_slice3_c1 (
    .a    (s1_q.a_hi[7:4]),
    .b    (s1_q.b_hi[7:4]),
    .cin  (1'b1),
    .sum  (s2_sum3_c1),
    .cout (c16_c1)
  );

  // Carry-select chain keyed on the registered c8, then borrow and overflow.
  always_comb begin
    c12       = s1_q.c8 ? c12_c1 : c12_c0;
    c16       = c12 ? c16_c1 : c16_c0;
    diff_full = {(c12 ? s2_sum3_c1 : s2_sum3_c0),
                 (s1_q.c8 ? s2_sum2_c1 : s2_sum2_c0),
                 s1_q.diff_lo};
    bout_d    = ~c16;
    ovf_d     = (s1_q.a_hi[HALF-1] ^ s1_q.b_hi[HALF-1]) &
                (diff_full[WIDTH-1] ^ s1_q.a_hi[HALF-1]);
  end

  // Stage-2 valid flag follows stage 1 whenever stage 1 advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
    end
  end

  // Output registers load only from a real beat, so bubbles never reach them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Diff <= '0;
      Bout <= 1'b0;
      Ovf  <= 1'b0;
    end else if (s2_load) begin
      Diff <= diff_full;
      Bout <= bout_d;
      Ovf  <= ovf_d;
    end
  end

  assign out_valid = s2_valid;

endmodule : csel_sub_16b_pipe

// File: doc/csel_sub_16b_pipe.md
CSEL_SUB_16B_PIPE -- requirements
Module: csel_sub_16b_pipe

Interface
- REQ-001: Parameters: none; operand width fixed at 16, slice width fixed at 4.
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: rst_n  input  1  reset, synchronous and active-low; sampled on rising clk only.
- REQ-004: in_valid  input  1  operand beat offered.
- REQ-005: in_ready  output  1  block accepts the offered beat this cycle.
- REQ-006: A  input  16  minuend, unsigned or two's-complement.
- REQ-007: B  input  16  subtrahend.
- REQ-008: Bin  input  1  borrow-in.
- REQ-009: out_valid  output  1  result beat present.
- REQ-010: out_ready  input  1  downstream accepts the result beat.
- REQ-011: Diff  output  16  A - B - Bin modulo 2^16.
- REQ-012: Bout  output  1  borrow-out; 1 when unsigned A < B + Bin.
- REQ-013: Ovf  output  1  two's-complement overflow of A - B - Bin.

Function
- REQ-014: Arithmetic shall be A + ~B + ~Bin; Bout = NOT carry-out of bit 15; Ovf = (A[15] != B[15]) AND (Diff[15] != A[15]).
- REQ-015: Stage 1 shall compute Diff[7:0] and carry c8 (bits 3:0 ripple from ~Bin; bits 7:4 carry-selected with both carry assumptions, muxed by c4), and register Diff[7:0], c8, A[15:8], B[15:8].
- REQ-016: Stage 2 shall compute Diff[15:8] by the same carry-select scheme keyed on the registered c8, then derive Bout and Ovf, and register all outputs.
- REQ-017: Latency shall be exactly 2 cycles from an accepted input (in_valid & in_ready) to out_valid, with no stall.
- REQ-018: Throughput shall be one beat per cycle while out_ready = 1.
- REQ-019: Each stage holds a valid flag; a stage loads when it is empty or its contents move forward in the same cycle.
- REQ-020: in_ready = NOT s1_valid OR s1 advancing; s1 advances when NOT s2_valid OR out_ready.
- REQ-021: With out_ready = 0 and both stages full, in_ready shall be 0, and Diff/Bout/Ovf/out_valid shall hold unchanged.
- REQ-022: Once asserted, out_valid shall stay high with stable outputs until out_ready = 1.
- REQ-023: Simultaneous accept and drain in the same cycle shall lose no beat and duplicate no beat.
- REQ-024: Registered data shall change only on a stage load; data from a bubble shall never appear with out_valid = 1.
- REQ-025: in_ready shall depend combinationally on out_ready only; no input-to-output data path shall be combinational.

Reset
- REQ-026: On rst_n = 0 at a clock edge, s1_valid and s2_valid clear; out_valid = 0, Diff = 0, Bout = 0, Ovf = 0.
- REQ-027: in_ready shall be 1 in the first cycle after reset deasserts.
- REQ-028: Reset mid-operation shall discard all in-flight beats; no stale result shall emerge after reset.

Structure
- REQ-029: A shared package shall hold the width constant (16), the slice constant (4), and the stage-1 payload record (low difference, c8, upper A, upper B).
- REQ-030: One sub-module, sub_slice_4b: combinational 4-bit add of a and ~b with carry-in, giving the sum and carry-out; instantiated twice per selected slice.

Verification
- REQ-031: A=22, B=22, Bin=1, out_ready=1 -> 2 cycles later Diff=0xFFFF, Bout=1, Ovf=0.
- REQ-032: A=21, B=20, Bin=0 -> Diff=0x0001, Bout=0, Ovf=0; A=0x8000, B=0x0001, Bin=0 -> Diff=0x7FFF, Bout=0, Ovf=1.
- REQ-033: Ten back-to-back beats (A=i*0x1111, B=0x0F0F, Bin=i%2), out_ready=1 -> ten results in order on consecutive cycles, each matching the REQ-014 model.
- REQ-034: out_ready=0 for 5 cycles with 3 beats offered -> 2 accepted, in_ready=0 after that, outputs stable; release -> all 3 beats delivered in order.
- REQ-035: rst_n=0 for 1 cycle with both stages full -> out_valid=0 and all outputs 0 next cycle; the next accepted beat A=0x0003, B=0x0005 gives Diff=0xFFFE, Bout=1.
- REQ-036: Random 10k beats with random out_ready and in_valid -> scoreboard matches A-B-Bin, Bout, and Ovf exactly.
